tot_data_assembler: RTL
=======================

TOT_DATA_ASSEMBLER -- requirements
Module: tot_data_assembler

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, output FIFO entry count (power of 2, 2..16).
REQ-002 The module SHALL have parameter ERRCNT_W, default 8, width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream sample valid (fine encoder result plus coarse count).
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 fine_bin  input  5  fine phase code from TOT fine encoder, legal 0..20, 31 = encoder error.
REQ-008 fine_err  input  1  fine encoder errorFlag.
REQ-009 coarse  input  4  coarse TOT period count, 0..15.
REQ-010 out_valid  output  1  assembled word available.
REQ-011 out_ready  input  1  downstream accepts word.
REQ-012 tot_code  output  9  assembled TOT code.
REQ-013 tot_err  output  1  error flag for the word on tot_code.
REQ-014 err_count  output  ERRCNT_W  number of accepted samples flagged in error, saturating.
REQ-015 err_clr  input  1  synchronous clear of err_count.

Function
REQ-016 A sample SHALL be accepted when in_valid and in_ready are both 1 on a rising edge; otherwise inputs SHALL be ignored.
REQ-017 in_ready SHALL equal 1 exactly when the FIFO holds fewer than FIFO_DEPTH entries; no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-018 A sample SHALL be in error when fine_err=1, or fine_bin is in 21..31.
REQ-019 For a non-error sample, tot_code SHALL be coarse*21 + fine_bin, computed at 9 bits without truncation (max 335).
REQ-020 For an error sample, tot_code SHALL be 9'h1FF and tot_err SHALL be 1; otherwise tot_err SHALL be 0.
REQ-021 The computed word {tot_err, tot_code} SHALL be written into the FIFO on the accepting edge; out_valid SHALL rise the following cycle if the FIFO was empty (latency 1 cycle).
REQ-022 out_valid SHALL be 1 whenever the FIFO is non-empty; tot_code/tot_err SHALL present the oldest entry and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 An entry SHALL be removed when out_valid and out_ready are both 1 on a rising edge.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-025 out_ready=1 with the FIFO empty SHALL have no effect.
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with one extra bit to distinguish full from empty.
REQ-027 err_count SHALL increment by 1 on each accepted error sample and SHALL saturate at all-ones.
REQ-028 err_clr=1 SHALL set err_count to 0 on that edge; if an error sample is accepted on the same edge, err_count SHALL become 1.
REQ-029 The module SHALL contain no combinational path from out_ready to in_ready.

Reset
REQ-030 While reset=1 on a rising edge, FIFO pointers and occupancy SHALL clear to empty and err_count SHALL clear to 0.
REQ-031 From the first edge with reset=1: out_valid=0, in_ready=1, tot_code=0, tot_err=0.
REQ-032 Reset SHALL take priority over in_valid, out_ready and err_clr; entries in flight at reset SHALL be discarded.
REQ-033 No sample SHALL be accepted on an edge where reset=1.

Verification
REQ-034 Reset, then one sample coarse=3, fine_bin=7, fine_err=0, out_ready=1 -> next cycle out_valid=1, tot_code=70, tot_err=0; entry popped, out_valid=0 after.
REQ-035 coarse=15, fine_bin=20 -> tot_code=335; fine_bin=31, fine_err=1 -> tot_code=0x1FF, tot_err=1, err_count increments by 1; fine_bin=25, fine_err=0 -> tot_err=1.
REQ-036 out_ready=0, push 5 samples with in_valid=1 -> 4 accepted, in_ready=0 after 4th, 5th held; release out_ready -> words emerge in push order, stable while stalled.
REQ-037 FIFO full, in_valid=1, out_ready=1 same cycle -> one pop, no push that cycle (in_ready=0); push accepted next cycle; order preserved across pointer wrap over 20 words.
REQ-038 300 consecutive error samples -> err_count saturates at 255; err_clr with simultaneous error sample -> err_count=1.
REQ-039 Assert reset with 3 entries queued -> next cycle out_valid=0, in_ready=1, err_count=0; first sample after reset emerges alone.

Source files
------------

// File: rtl/tot_data_assembler.sv
// TOT data assembler: combines coarse period count and fine phase code into a
// 9-bit TOT word, queues {err, code} in a small FIFO and counts error samples.
module tot_data_assembler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          fine_bin,
  input  logic                fine_err,
  input  logic [3:0]          coarse,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8:0]          tot_code,
  output logic                tot_err,
  output logic [ERRCNT_W-1:0] err_count,
  input  logic                err_clr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [9:0]          mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]         occ;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  logic       push, pop, empty, full;
  logic       sample_err;
  logic [8:0] code_calc;
  logic [9:0] word_d;

  // Pointers carry one extra bit so occupancy == FIFO_DEPTH is distinguishable from empty.
  assign occ   = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (occ == (AW + 1)'(FIFO_DEPTH));

  // in_ready depends on registered pointers only, never on out_ready.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~reset;
  assign pop       = out_valid & out_ready;

  assign sample_err = fine_err | (fine_bin > 5'd20);
  assign code_calc  = (9'(coarse) * 9'd21) + 9'(fine_bin);
  assign word_d     = sample_err ? {1'b1, 9'h1FF} : {1'b0, code_calc};

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (err_clr) begin
      err_count_d = (push && sample_err) ? ERRCNT_W'(1) : '0;
    end else if (push && sample_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_count_q <= err_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_d;
  end

  // Storage is not reset, so the output word is forced to zero while empty.
  assign tot_code  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]][8:0];
  assign tot_err   = empty ? 1'b0 : mem_q[rd_ptr_q[AW-1:0]][9];
  assign err_count = err_count_q;

endmodule
